// File: rtl/mem_access_fsm.sv
// Data-memory access sequencer.
// Runs read, write and indirect (pointer-then-access) memory operations on
// behalf of the pipeline controller. Every output is registered, so the
// outputs always reflect the state the FSM has just entered.
module mem_access_fsm #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        mem_state,
    input  logic [DATA_W-1:0] IR_Exec,
    input  logic [DATA_W-1:0] M_Addr,
    input  logic [DATA_W-1:0] M_Data,
    input  logic [DATA_W-1:0] DMem_dout,
    input  logic              DMem_ready,
    output logic              DMem_en,
    output logic              DMem_rd,
    output logic [DATA_W-1:0] DMem_addr,
    output logic [DATA_W-1:0] DMem_din,
    output logic [DATA_W-1:0] memout,
    output logic              complete_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_IND_PTR,
        S_IND_READ,
        S_IND_WRITE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0] data_q, data_nxt;
    logic              sti_q, sti_nxt;
    logic [DATA_W-1:0] memout_nxt;
    logic              cmpl_nxt;
    logic              en_nxt;
    logic              rd_nxt;
    logic [DATA_W-1:0] dmem_addr_nxt;
    logic [DATA_W-1:0] dmem_din_nxt;

    // State, latched request and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            addr_q        <= '0;
            data_q        <= '0;
            sti_q         <= 1'b0;
            DMem_en       <= 1'b0;
            DMem_rd       <= 1'b1;
            DMem_addr     <= '0;
            DMem_din      <= '0;
            memout        <= '0;
            complete_data <= 1'b0;
        end else begin
            state         <= state_nxt;
            addr_q        <= addr_nxt;
            data_q        <= data_nxt;
            sti_q         <= sti_nxt;
            DMem_en       <= en_nxt;
            DMem_rd       <= rd_nxt;
            DMem_addr     <= dmem_addr_nxt;
            DMem_din      <= dmem_din_nxt;
            memout        <= memout_nxt;
            complete_data <= cmpl_nxt;
        end
    end

    // Next-state, latched-request and next-output decode
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        data_nxt      = data_q;
        sti_nxt       = sti_q;
        memout_nxt    = memout;
        cmpl_nxt      = 1'b0;
        en_nxt        = 1'b0;
        rd_nxt        = 1'b1;
        dmem_addr_nxt = DMem_addr;
        dmem_din_nxt  = DMem_din;

        case (state)
            S_IDLE: begin
                if (mem_state <= 3'd2) begin
                    // Capture the request; later input changes cannot disturb it.
                    addr_nxt = M_Addr;
                    data_nxt = M_Data;
                    sti_nxt  = (IR_Exec[DATA_W-1 -: 4] == 4'b1011);
                    case (mem_state)
                        3'd0:    state_nxt = S_READ;
                        3'd1:    state_nxt = S_IND_PTR;
                        default: state_nxt = S_WRITE;
                    endcase
                end
            end
            S_READ, S_IND_READ: begin
                if (DMem_ready) begin
                    memout_nxt = DMem_dout;
                    cmpl_nxt   = 1'b1;
                    state_nxt  = S_DONE;
                end
            end
            S_IND_PTR: begin
                if (DMem_ready) begin
                    // The pointer replaces the address for the second access.
                    addr_nxt  = DMem_dout;
                    state_nxt = sti_q ? S_IND_WRITE : S_IND_READ;
                end
            end
            S_WRITE, S_IND_WRITE: begin
                if (DMem_ready) begin
                    cmpl_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // Wait for the controller to drop the request so it is not re-run.
                if (mem_state >= 3'd3) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        // Outputs follow the state being entered, so they are stable while waiting.
        case (state_nxt)
            S_READ, S_IND_PTR, S_IND_READ: begin
                en_nxt        = 1'b1;
                dmem_addr_nxt = addr_nxt;
                dmem_din_nxt  = data_nxt;
            end
            S_WRITE, S_IND_WRITE: begin
                en_nxt        = 1'b1;
                rd_nxt        = 1'b0;
                dmem_addr_nxt = addr_nxt;
                dmem_din_nxt  = data_nxt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_fsm.sv
// Self-checking bench for mem_access_fsm: directed vector table, hand-written
// reset / illegal-code sequences and randomized transactions checked against
// a transaction-level model with a behavioural data memory.
module tb_mem_access_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mem_state;
    logic [15:0] IR_Exec, M_Addr, M_Data, DMem_dout;
    logic        DMem_ready;
    logic        DMem_en, DMem_rd, complete_data;
    logic [15:0] DMem_addr, DMem_din, memout;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:65535];
    logic [15:0] model_memout;

    typedef struct {
        logic [2:0]  ms;
        logic [15:0] ir;
        logic [15:0] a;
        logic [15:0] d;
        int          lat;
        int          hold;
        logic        pre_en;
        logic [15:0] pre_a;
        logic [15:0] pre_v;
        logic [15:0] exp_memout;
        int          exp_cyc;
    } vec_t;

    vec_t vt [5];

    mem_access_fsm #(.DATA_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_state    (mem_state),
        .IR_Exec      (IR_Exec),
        .M_Addr       (M_Addr),
        .M_Data       (M_Data),
        .DMem_dout    (DMem_dout),
        .DMem_ready   (DMem_ready),
        .DMem_en      (DMem_en),
        .DMem_rd      (DMem_rd),
        .DMem_addr    (DMem_addr),
        .DMem_din     (DMem_din),
        .memout       (memout),
        .complete_data(complete_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_en"},     32'(DMem_en),       0);
        check({tag, "_rd"},     32'(DMem_rd),       1);
        check({tag, "_addr"},   32'(DMem_addr),     0);
        check({tag, "_din"},    32'(DMem_din),      0);
        check({tag, "_memout"}, 32'(memout),        0);
        check({tag, "_cmpl"},   32'(complete_data), 0);
    endtask

    // Issue one request from IDLE (called at a negedge with the FSM idle),
    // act as the data memory with a fixed ready latency, then hold the
    // request for 'hold' cycles in DONE and release it. Returns the number
    // of cycles from the accepting edge to the observed complete pulse.
    task automatic run_txn(input logic [2:0] ms, input logic [15:0] ir,
                           input logic [15:0] a, input logic [15:0] d,
                           input int lat, input int hold, output int cyc);
        logic [15:0] ea [2];
        logic        erd [2];
        logic [15:0] ed [2];
        logic [15:0] ptr;
        int          n, acc, wcnt;
        bit          got;

        // Expected accesses from the operation's definition
        ea[1] = '0; erd[1] = 1'b1; ed[1] = '0;
        ea[0] = a;  ed[0] = d;
        if (ms == 3'd0) begin
            erd[0] = 1'b1; n = 1; model_memout = mem[a];
        end else if (ms == 3'd2) begin
            erd[0] = 1'b0; n = 1;
        end else begin
            ptr = mem[a];
            erd[0] = 1'b1; ea[1] = ptr; ed[1] = d; n = 2;
            if (ir[15:12] == 4'hB) erd[1] = 1'b0;
            else begin erd[1] = 1'b1; model_memout = mem[ptr]; end
        end

        mem_state = ms; IR_Exec = ir; M_Addr = a; M_Data = d; DMem_ready = 1'b0;
        acc = 0; wcnt = 0; got = 0; cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            DMem_ready = 1'b0;
            DMem_dout  = 16'($urandom);
            if (complete_data) begin
                got = 1;
                check("acc_count", 32'(acc), 32'(n));
                check("memout", 32'(memout), 32'(model_memout));
                check("en_in_done", 32'(DMem_en), 0);
                check("latency", 32'(cyc), 32'(n * (lat + 1) + 1));
                mem_state = ms;
            end else begin
                check("access_phase", 32'(DMem_en), 32'(acc < n));
                if (DMem_en && acc < n) begin
                    check("addr", 32'(DMem_addr), 32'(ea[acc]));
                    check("rd", 32'(DMem_rd), 32'(erd[acc]));
                    if (!erd[acc]) check("din", 32'(DMem_din), 32'(ed[acc]));
                    if (wcnt == lat) begin
                        DMem_ready = 1'b1;
                        if (DMem_rd) DMem_dout = mem[DMem_addr];
                        else         mem[DMem_addr] = DMem_din;
                        acc++;
                        wcnt = 0;
                    end else begin
                        wcnt++;
                    end
                end
                // Request, address and data changes after acceptance must be ignored.
                mem_state = 3'($urandom_range(0, 7));
                IR_Exec   = 16'($urandom);
                M_Addr    = 16'($urandom);
                M_Data    = 16'($urandom);
            end
        end
        if (!got) check("complete_timeout", 32'(got), 1);

        DMem_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            mem_state  = ms;
            DMem_ready = 1'($urandom);
            @(negedge clk);
            check("held_no_en", 32'(DMem_en), 0);
            check("held_no_pulse", 32'(complete_data), 0);
            check("memout_hold", 32'(memout), 32'(model_memout));
        end
        mem_state  = 3'($urandom_range(3, 7));
        DMem_ready = 1'b0;
        @(negedge clk);
        check("release_en", 32'(DMem_en), 0);
        check("release_pulse", 32'(complete_data), 0);
    endtask

    initial begin
        int cyc;
        logic [15:0] ir;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h3000] = 16'hBEEF;
        mem[16'h3010] = 16'h4000;
        mem[16'h4000] = 16'h1234;

        //          ms    ir        a         d         lat hold pre   pre_a     pre_v     exp_mo    cyc
        vt[0] = '{3'd0, 16'h0000, 16'h3000, 16'h0000, 0, 2, 1'b0, 16'h0000, 16'h0000, 16'hBEEF, 2};
        vt[1] = '{3'd1, 16'hA000, 16'h3010, 16'h0000, 3, 1, 1'b0, 16'h0000, 16'h0000, 16'h1234, 9};
        vt[2] = '{3'd1, 16'hB000, 16'h3010, 16'h00AA, 3, 0, 1'b1, 16'h3010, 16'h4002, 16'h1234, 9};
        vt[3] = '{3'd2, 16'h0000, 16'h3020, 16'h5555, 0, 5, 1'b0, 16'h0000, 16'h0000, 16'h1234, 2};
        vt[4] = '{3'd1, 16'h1FFF, 16'h3010, 16'h0000, 1, 1, 1'b0, 16'h0000, 16'h0000, 16'h00AA, 5};

        rst = 1'b1; mem_state = 3'd3; IR_Exec = '0; M_Addr = '0; M_Data = '0;
        DMem_dout = '0; DMem_ready = 1'b0;
        model_memout = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("post_reset");

        // Directed vectors
        for (int i = 0; i < 5; i++) begin
            if (vt[i].pre_en) mem[vt[i].pre_a] = vt[i].pre_v;
            run_txn(vt[i].ms, vt[i].ir, vt[i].a, vt[i].d, vt[i].lat, vt[i].hold, cyc);
            check($sformatf("tbl%0d_memout", i), 32'(memout), 32'(vt[i].exp_memout));
            check($sformatf("tbl%0d_cycles", i), 32'(cyc), 32'(vt[i].exp_cyc));
        end
        check("ind_store_mem", 32'(mem[16'h4002]), 32'h00AA);
        check("write_mem", 32'(mem[16'h3020]), 32'h5555);

        // Out-of-range request codes never start an access, stray ready ignored
        for (int i = 0; i < 8; i++) begin
            mem_state  = (i < 4) ? 3'd5 : 3'(4 + (i % 4));
            DMem_ready = 1'b1;
            DMem_dout  = 16'($urandom);
            @(negedge clk);
            check("illegal_en", 32'(DMem_en), 0);
            check("illegal_pulse", 32'(complete_data), 0);
        end
        DMem_ready = 1'b0;
        mem_state  = 3'd3;

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            ir = ($urandom_range(0, 1) != 0) ? {4'hB, 12'($urandom)} : 16'($urandom);
            run_txn(3'($urandom_range(0, 2)), ir, 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), cyc);
        end

        // Reset while a read waits, with ready arriving on the reset edge
        mem_state = 3'd0; M_Addr = 16'h3000; DMem_ready = 1'b0;
        @(negedge clk);
        check("midrst_started", 32'(DMem_en), 1);
        @(negedge clk);
        rst = 1'b1; DMem_ready = 1'b1; DMem_dout = 16'hFFFF;
        @(negedge clk);
        check_reset_vals("midrst");
        rst = 1'b0; DMem_ready = 1'b0; mem_state = 3'd3;
        model_memout = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_pulse", 32'(complete_data), 0);
            check("midrst_no_en", 32'(DMem_en), 0);
        end

        for (int t = 0; t < 10; t++) begin
            ir = ($urandom_range(0, 1) != 0) ? {4'hB, 12'($urandom)} : 16'($urandom);
            run_txn(3'($urandom_range(0, 2)), ir, 16'($urandom), 16'($urandom),
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), cyc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_fsm.md
MEM_ACCESS_FSM -- requirements
Module: mem_access_fsm

Interface
REQ-001 SHALL have one clock and reset: synchronous reset, active-high.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 mem_state  input  3  access request from the pipeline controller: 0 read, 1 indirect, 2 write, 3 idle; 4-7 treated as idle.
REQ-005 IR_Exec  input  16  executing instruction; bits [15:12]=1011 (STI) select indirect-store, any other value selects indirect-load.
REQ-006 M_Addr  input  16  effective address from execute.
REQ-007 M_Data  input  16  store data from execute.
REQ-008 DMem_dout  input  16  data memory read data.
REQ-009 DMem_ready  input  1  data memory completes the current access this cycle.
REQ-010 DMem_en  output  1  access valid to data memory.
REQ-011 DMem_rd  output  1  1 = read, 0 = write; meaningful only while DMem_en=1.
REQ-012 DMem_addr  output  16  access address.
REQ-013 DMem_din  output  16  write data.
REQ-014 memout  output  16  last completed load result.
REQ-015 complete_data  output  1  one-cycle pulse: the requested operation finished.

Function
REQ-016 States: IDLE, READ, IND_PTR, IND_READ, IND_WRITE, WRITE, DONE; all outputs registered.
REQ-017 IDLE: if mem_state in {0,1,2}, SHALL latch M_Addr, M_Data and the STI flag (IR_Exec[15:12]) and go to READ, IND_PTR or WRITE respectively.
REQ-018 IDLE with mem_state 3-7: SHALL stay in IDLE with DMem_en=0.
REQ-019 READ, IND_PTR, IND_READ: DMem_en=1, DMem_rd=1; WRITE, IND_WRITE: DMem_en=1, DMem_rd=0, DMem_din=latched data.
REQ-020 Each access state SHALL hold DMem_en, DMem_rd, DMem_addr and DMem_din stable until a cycle with DMem_ready=1.
REQ-021 Access states do not time out: the FSM SHALL wait for DMem_ready indefinitely.
REQ-022 DMem_ready=1 while DMem_en=0 SHALL be ignored.
REQ-023 READ completion: memout<=DMem_dout, go to DONE.
REQ-024 IND_PTR completion: latched address<=DMem_dout (pointer); next state IND_WRITE if STI flag else IND_READ.
REQ-025 IND_READ completion: memout<=DMem_dout, go to DONE.
REQ-026 WRITE and IND_WRITE completion: go to DONE; memout unchanged.
REQ-027 complete_data SHALL be 1 for exactly the one cycle after the final DMem_ready; memout is valid in that same cycle.
REQ-028 memout SHALL hold its value until the next load completion.
REQ-029 DONE: DMem_en=0; SHALL remain in DONE until mem_state is 3-7, then go to IDLE. A held request SHALL NOT be re-executed.
REQ-030 Minimum latency (ready tied high): request seen in IDLE at cycle t -> DMem_en at t+1 -> complete_data at t+2 for read or write, and at t+3 for indirect.
REQ-031 mem_state changes after acceptance SHALL be ignored until DONE.
REQ-032 Address and data changes after acceptance SHALL be ignored.

Reset
REQ-033 rst=1 at a rising edge: state IDLE, DMem_en=0, DMem_rd=1, DMem_addr=0, DMem_din=0, memout=0, complete_data=0, latched regs 0.
REQ-034 rst mid-access SHALL abandon the access: no complete_data pulse; DMem_en=0 from the edge where rst is sampled.
REQ-035 rst has priority over DMem_ready arriving in the same cycle.

Verification
REQ-036 Read: mem_state=0, M_Addr=x3000, ready high, DMem_dout=xBEEF -> one access with rd=1 at x3000; complete_data pulse 2 cycles after request; memout=xBEEF.
REQ-037 Indirect load: mem_state=1, IR_Exec=xA000, M_Addr=x3010, mem[x3010]=x4000, mem[x4000]=x1234, ready after 3 cycles per access -> reads at x3010 then x4000; memout=x1234; single complete_data pulse.
REQ-038 Indirect store: mem_state=1, IR_Exec=xB000, M_Data=x00AA, pointer x4002 -> read at x3010, then write x00AA to x4002 with rd=0; memout unchanged.
REQ-039 Write with held request: mem_state=2 held for 6 cycles, addr x3020, data x5555 -> exactly one write; FSM waits in DONE until mem_state=3.
REQ-040 Reset mid-access: rst during READ while ready is low -> DMem_en=0 the next cycle, no complete_data, all outputs at reset values.
REQ-041 Illegal code: mem_state=5 -> DMem_en stays 0 and complete_data never pulses.
